// File: rtl/hex_display_pkg.sv
// hex_display_pkg
//   Shared definitions for the four-digit hex display scanner.
//   NUM_DIGITS   : number of multiplexed digits in one frame
//   digit_idx_t  : index of the digit currently being driven
//   ANODES_OFF   : active-low anode pattern with every digit dark
//   digit_of()   : extracts one hex nibble from a 16-bit display word
package hex_display_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [1:0] digit_idx_t;

  localparam logic [3:0] ANODES_OFF = 4'b1111;

  function automatic logic [3:0] digit_of(input logic [15:0] word, input digit_idx_t i);
    return word[4*i +: 4];
  endfunction

endpackage

// File: rtl/tick_divider.sv
// tick_divider
//   Free-running prescaler that counts 0..DIV-1 and wraps. tick is high
//   for the single cycle in which the count sits at DIV-1.
//   Ports:
//     clk   : clock, rising edge
//     reset : asynchronous active-high reset, clears the count
//     tick  : one-cycle strobe every DIV cycles
module tick_divider #(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  assign tick = (count == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hex_display_scanner.sv
// hex_display_scanner
//   Time-multiplexes a 16-bit value onto four hex digits. Each digit is
//   driven for REFRESH_DIV cycles. New values are captured by load into a
//   pending buffer and only moved into the displayed (shadow) word at the
//   end of a frame, so a frame never shows a mix of old and new digits.
//   Ports:
//     clk        : clock, rising edge
//     reset      : asynchronous active-high reset
//     value      : 16-bit word to display, digit 0 = value[3:0]
//     load       : one-cycle strobe capturing value
//     lzb_en     : leading-zero blanking enable
//     nibble     : hex code of the current digit for the 7-segment decoder
//     anodes     : active-low digit enables, one-hot-low or all high
//     blank      : current digit is suppressed
//     frame_done : one-cycle pulse as the scan returns to digit 0
module hex_display_scanner
  import hex_display_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic        load,
  input  logic        lzb_en,
  output logic [3:0]  nibble,
  output logic [3:0]  anodes,
  output logic        blank,
  output logic        frame_done
);

  localparam digit_idx_t LAST_IDX = digit_idx_t'(NUM_DIGITS - 1);

  logic        tick;
  digit_idx_t  idx;
  logic [15:0] shadow;
  logic [15:0] pending_data;
  logic        pending_flag;
  logic        lzb_q;
  logic        commit;
  logic        upper_zero;

  tick_divider #(
    .DIV (REFRESH_DIV)
  ) u_tick_divider (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // The frame boundary is the tick that moves the scan from the last digit
  // back to digit 0; this is the only moment the displayed word may change.
  assign commit = tick && (idx == LAST_IDX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx <= '0;
    end else if (tick) begin
      idx <= idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= commit;
    end
  end

  // A load landing exactly on the commit cycle bypasses the pending buffer
  // and goes straight to the shadow word, leaving nothing pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow       <= '0;
      pending_data <= '0;
      pending_flag <= 1'b0;
    end else if (commit) begin
      if (load) begin
        shadow <= value;
      end else if (pending_flag) begin
        shadow <= pending_data;
      end
      pending_flag <= 1'b0;
    end else if (load) begin
      pending_data <= value;
      pending_flag <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lzb_q <= 1'b0;
    end else begin
      lzb_q <= lzb_en;
    end
  end

  // A digit is a leading zero when it and every more significant digit are
  // zero; digit 0 always stays lit so a zero value still shows "0".
  always_comb begin
    upper_zero = 1'b0;
    case (idx)
      2'd1:    upper_zero = (shadow[15:4] == 12'h000);
      2'd2:    upper_zero = (shadow[15:8] == 8'h00);
      2'd3:    upper_zero = (shadow[15:12] == 4'h0);
      default: upper_zero = 1'b0;
    endcase
  end

  always_comb begin
    nibble = digit_of(shadow, idx);
    blank  = lzb_q && upper_zero;
    anodes = blank ? ANODES_OFF : ~(4'b0001 << idx);
  end

endmodule
